// File: rtl/regfile_write_decoder.sv
// Register-file write decoder: binary address -> registered one-hot enable (1 cycle), plus a pending-write scoreboard that stalls via issue_ready.
// Optional checker under REGFILE_WRDEC_CHECK_EN drives a sticky err for bad retires and stall timeouts.
module regfile_write_decoder #(
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = ADDR_W + 1,
  localparam int NUM_REGS = 2 ** ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  output logic                issue_ready,
  input  logic                retire_en,
  input  logic [ADDR_W-1:0]   retire_addr,
  output logic [NUM_REGS-1:0] wr_onehot,
  output logic                wr_valid,
  output logic [NUM_REGS-1:0] busy,
  output logic [CNT_W-1:0]    busy_cnt,
  output logic                err
);

  // ZERO_REG == NUM_REGS (or larger) means there is no hardwired-zero register.
  localparam bit                ZERO_EN   = (ZERO_REG < NUM_REGS);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [NUM_REGS-1:0] r_onehot;
  logic                r_valid;
  logic [NUM_REGS-1:0] r_busy;
  logic [CNT_W-1:0]    r_busy_cnt;

  logic                w_wr_zero;
  logic                w_rt_zero;
  logic                w_bypass;
  logic                w_ready;
  logic                w_accept;
  logic                w_set;
  logic                w_clr;
  logic                w_inc;
  logic                w_dec;
  logic [NUM_REGS-1:0] w_set_vec;
  logic [NUM_REGS-1:0] w_clr_vec;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;

  always_comb begin
    w_wr_zero = ZERO_EN && (wr_addr == ZERO_ADDR);
    w_rt_zero = ZERO_EN && (retire_addr == ZERO_ADDR);
    w_bypass  = retire_en && (retire_addr == wr_addr);
    w_ready   = w_wr_zero || !r_busy[wr_addr] || w_bypass;
    w_accept  = wr_en && w_ready;
    w_set     = w_accept && !w_wr_zero;
    w_clr     = retire_en && !w_rt_zero;

    w_set_vec = '0;
    if (w_set) w_set_vec[wr_addr] = 1'b1;
    w_clr_vec = '0;
    if (w_clr) w_clr_vec[retire_addr] = 1'b1;

    // Set wins over a same-register retire, so the bit simply stays high.
    w_busy_nxt = (r_busy & ~w_clr_vec) | w_set_vec;

    w_inc     = w_set && !r_busy[wr_addr];
    w_dec     = w_clr && r_busy[retire_addr] && !(w_set && (retire_addr == wr_addr));
    w_cnt_nxt = r_busy_cnt + CNT_W'(w_inc) - CNT_W'(w_dec);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_onehot   <= '0;
      r_valid    <= 1'b0;
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_onehot   <= w_set_vec;
      r_valid    <= w_set;
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  assign issue_ready = w_ready;
  assign wr_onehot   = r_onehot;
  assign wr_valid    = r_valid;
  assign busy        = r_busy;
  assign busy_cnt    = r_busy_cnt;

`ifdef REGFILE_WRDEC_CHECK_EN
  logic             r_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_stall_sat;
  logic             w_stall;
  logic             w_bad_retire;

  assign w_stall      = wr_en && !w_ready;
  assign w_bad_retire = w_clr && !r_busy[retire_addr];

  // r_stall_sat marks that 2**CNT_W stall cycles have elapsed; one more is a timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
      r_stall_sat <= 1'b0;
    end else begin
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        if (&r_stall_cnt) r_stall_sat <= 1'b1;
      end else begin
        r_stall_cnt <= '0;
        r_stall_sat <= 1'b0;
      end
      if (w_bad_retire || (w_stall && r_stall_sat)) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_decoder.sv
// Directed self-checking bench for regfile_write_decoder (default parameters).
module tb_regfile_write_decoder;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic        issue_ready;
  logic        retire_en;
  logic [4:0]  retire_addr;
  logic [31:0] wr_onehot;
  logic        wr_valid;
  logic [31:0] busy;
  logic [5:0]  busy_cnt;
  logic        err;

  int checks = 0;
  int errors = 0;

`ifdef REGFILE_WRDEC_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  regfile_write_decoder dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .issue_ready(issue_ready), .retire_en(retire_en), .retire_addr(retire_addr),
    .wr_onehot(wr_onehot), .wr_valid(wr_valid), .busy(busy),
    .busy_cnt(busy_cnt), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; retire_en = 1'b0; retire_addr = '0;
    #12;
    checks++; if (wr_onehot !== 32'h0) begin errors++; $display("FAIL reset_onehot got %h exp 0", wr_onehot); end
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", wr_valid); end
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", busy_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_write();
    wr_en = 1'b1; wr_addr = 5'd3;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", issue_ready); end
    step();
    wr_en = 1'b0;
    checks++; if (wr_onehot !== 32'h0000_0008) begin errors++; $display("FAIL single_onehot got %h exp 00000008", wr_onehot); end
    checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", wr_valid); end
    checks++; if (busy !== 32'h0000_0008) begin errors++; $display("FAIL single_busy got %h exp 00000008", busy); end
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", busy_cnt); end
    step();
    checks++; if (wr_onehot !== 32'h0) begin errors++; $display("FAIL single_pulse_onehot got %h exp 0", wr_onehot); end
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_valid got %b exp 0", wr_valid); end
    checks++; if (busy !== 32'h0000_0008) begin errors++; $display("FAIL single_hold_busy got %h exp 00000008", busy); end
  endtask

  task automatic test_stall_bypass();
    wr_en = 1'b1; wr_addr = 5'd3;
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", issue_ready); end
    step();
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL stall_valid got %b exp 0", wr_valid); end
    checks++; if (wr_onehot !== 32'h0) begin errors++; $display("FAIL stall_onehot got %h exp 0", wr_onehot); end
    retire_en = 1'b1; retire_addr = 5'd3;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready got %b exp 1", issue_ready); end
    step();
    checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid got %b exp 1", wr_valid); end
    checks++; if (wr_onehot !== 32'h0000_0008) begin errors++; $display("FAIL bypass_onehot got %h exp 00000008", wr_onehot); end
    checks++; if (busy !== 32'h0000_0008) begin errors++; $display("FAIL bypass_busy got %h exp 00000008", busy); end
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL bypass_cnt got %0d exp 1", busy_cnt); end
    wr_en = 1'b0;
    step();
    retire_en = 1'b0;
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL retire_busy got %h exp 0", busy); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL retire_cnt got %0d exp 0", busy_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL retire_err got %b exp 0", err); end
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_addr = 5'd31;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b exp 1", issue_ready); end
    step();
    wr_en = 1'b0;
    checks++; if (wr_onehot !== 32'h0) begin errors++; $display("FAIL zero_onehot got %h exp 0", wr_onehot); end
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL zero_valid got %b exp 0", wr_valid); end
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL zero_busy got %h exp 0", busy); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL zero_cnt got %0d exp 0", busy_cnt); end
    retire_en = 1'b1; retire_addr = 5'd31;
    step();
    retire_en = 1'b0;
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL zero_retire_cnt got %0d exp 0", busy_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL zero_retire_err got %b exp 0", err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_oh;
    for (int i = 0; i < 31; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i);
      step();
      exp_oh = 32'h1 << i;
      checks++; if (wr_onehot !== exp_oh) begin errors++; $display("FAIL b2b_onehot[%0d] got %h exp %h", i, wr_onehot, exp_oh); end
      checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp 1", i, wr_valid); end
      checks++; if (busy_cnt !== 6'(i + 1)) begin errors++; $display("FAIL b2b_cnt[%0d] got %0d exp %0d", i, busy_cnt, i + 1); end
    end
    wr_en = 1'b0;
    checks++; if (busy !== 32'h7fff_ffff) begin errors++; $display("FAIL b2b_busy got %h exp 7fffffff", busy); end
    for (int i = 0; i < 31; i++) begin
      retire_en = 1'b1; retire_addr = 5'(i);
      step();
      checks++; if (busy_cnt !== 6'(30 - i)) begin errors++; $display("FAIL drain_cnt[%0d] got %0d exp %0d", i, busy_cnt, 30 - i); end
      checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL drain_valid[%0d] got %b exp 0", i, wr_valid); end
    end
    retire_en = 1'b0;
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL drain_busy got %h exp 0", busy); end
  endtask

  task automatic test_mixed();
    wr_en = 1'b1; wr_addr = 5'd4;
    step();
    checks++; if (busy !== 32'h0000_0010) begin errors++; $display("FAIL mixed_busy0 got %h exp 00000010", busy); end
    wr_addr = 5'd6; retire_en = 1'b1; retire_addr = 5'd4;
    step();
    wr_en = 1'b0; retire_addr = 5'd6;
    checks++; if (busy !== 32'h0000_0040) begin errors++; $display("FAIL mixed_busy1 got %h exp 00000040", busy); end
    checks++; if (wr_onehot !== 32'h0000_0040) begin errors++; $display("FAIL mixed_onehot got %h exp 00000040", wr_onehot); end
    checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL mixed_cnt1 got %0d exp 1", busy_cnt); end
    step();
    retire_en = 1'b0;
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL mixed_cnt2 got %0d exp 0", busy_cnt); end
  endtask

  task automatic test_err();
    retire_en = 1'b1; retire_addr = 5'd7;
    step();
    retire_en = 1'b0;
    checks++; if (err !== ERR_EXP) begin errors++; $display("FAIL err_set got %b exp %b", err, ERR_EXP); end
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL err_busy got %h exp 0", busy); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL err_cnt got %0d exp 0", busy_cnt); end
    step();
    checks++; if (err !== ERR_EXP) begin errors++; $display("FAIL err_hold got %b exp %b", err, ERR_EXP); end
    reset = 1'b1;
    #2;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i);
      step();
    end
    wr_en = 1'b0;
    checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b exp 1", wr_valid); end
    checks++; if (busy_cnt !== 6'd5) begin errors++; $display("FAIL arst_pre_cnt got %0d exp 5", busy_cnt); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (wr_onehot !== 32'h0) begin errors++; $display("FAIL arst_onehot got %h exp 0", wr_onehot); end
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", wr_valid); end
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL arst_busy got %h exp 0", busy); end
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", busy_cnt); end
    @(negedge clk);
    reset = 1'b0;
    step();
    checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL arst_post_cnt got %0d exp 0", busy_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_stall_bypass();
    test_zero_reg();
    test_back_to_back();
    test_mixed();
    test_err();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
